// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned RegAwDefault = 5;

  // RUN: normal issue. MDU_WAIT: EX occupied by a multi-cycle MUL/DIV/REM.
  typedef enum logic {
    StRun     = 1'b0,
    StMduWait = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up on inc, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush control for the 5-stage core: load-use, branch squash,
// MDU occupancy of EX and data-memory back-pressure, plus stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAwDefault,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_is_mdu,
  input  logic              ex_branch_taken,
  input  logic              mdu_done,
  input  logic              mem_stall,
  output logic              pc_en,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              mdu_start,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  state_e state_q, state_d;
  logic   done_pend_q, done_pend_d;
  logic   load_use;
  logic   done;
  logic   branch_fire;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // A done pulse that arrived while frozen by memory is remembered in done_pend.
  assign done = mdu_done || done_pend_q;

  // Control outputs and next state; reset forces all controls low.
  always_comb begin
    pc_en        = 1'b0;
    en_if_id     = 1'b0;
    en_id_ex     = 1'b0;
    en_ex_mem    = 1'b0;
    en_mem_wb    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mdu_start    = 1'b0;
    branch_fire  = 1'b0;
    state_d      = state_q;
    done_pend_d  = done_pend_q;

    if (!rst) begin
      // Everything stays low.
    end else if (mem_stall) begin
      if (mdu_done) begin
        done_pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            branch_fire = 1'b1;
          end else if (ex_is_mdu) begin
            en_ex_mem    = 1'b1;
            en_mem_wb    = 1'b1;
            flush_ex_mem = 1'b1;
            mdu_start    = 1'b1;
            state_d      = StMduWait;
          end else if (load_use) begin
            en_id_ex    = 1'b1;
            en_ex_mem   = 1'b1;
            en_mem_wb   = 1'b1;
            flush_id_ex = 1'b1;
          end else begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '1;
          end
        end
        StMduWait: begin
          if (done) begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '1;
            done_pend_d = 1'b0;
            state_d     = StRun;
          end else begin
            en_ex_mem    = 1'b1;
            en_mem_wb    = 1'b1;
            flush_ex_mem = 1'b1;
          end
        end
      endcase
    end
  end

  // FSM state and pending-done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_en),
    .q   (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch_fire),
    .q   (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes expected controls from a
// rule-level model, a monitor pops and compares each cycle. A second instance
// with 4-bit counters exercises saturation.
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;

  // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, fl_ex_mem, start
  localparam logic [8:0] CtlZero   = 9'b00000_000_0;
  localparam logic [8:0] CtlAllEn  = 9'b11111_000_0;
  localparam logic [8:0] CtlBranch = 9'b11111_110_0;
  localparam logic [8:0] CtlMduGo  = 9'b00011_001_1;
  localparam logic [8:0] CtlMduHld = 9'b00011_001_0;
  localparam logic [8:0] CtlLdUse  = 9'b00111_010_0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_is_mdu = 0;
  logic ex_branch_taken = 0, mdu_done = 0, mem_stall = 0;

  logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mdu_start;
  logic [31:0] stall_cycles, flush_count;
  logic pc_en4, en_if_id4, en_id_ex4, en_ex_mem4, en_mem_wb4;
  logic flush_if_id4, flush_id_ex4, flush_ex_mem4, mdu_start4;
  logic [3:0] stall_cycles4, flush_count4;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(32)) u_dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rd (ex_rd), .ex_mem_read (ex_mem_read), .ex_is_mdu (ex_is_mdu),
    .ex_branch_taken (ex_branch_taken), .mdu_done (mdu_done), .mem_stall (mem_stall),
    .pc_en (pc_en), .en_if_id (en_if_id), .en_id_ex (en_id_ex), .en_ex_mem (en_ex_mem),
    .en_mem_wb (en_mem_wb), .flush_if_id (flush_if_id), .flush_id_ex (flush_id_ex),
    .flush_ex_mem (flush_ex_mem), .mdu_start (mdu_start),
    .stall_cycles (stall_cycles), .flush_count (flush_count)
  );

  hazard_ctrl #(.REG_AW(AW), .CNT_W(4)) u_dut4 (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rd (ex_rd), .ex_mem_read (ex_mem_read), .ex_is_mdu (ex_is_mdu),
    .ex_branch_taken (ex_branch_taken), .mdu_done (mdu_done), .mem_stall (mem_stall),
    .pc_en (pc_en4), .en_if_id (en_if_id4), .en_id_ex (en_id_ex4), .en_ex_mem (en_ex_mem4),
    .en_mem_wb (en_mem_wb4), .flush_if_id (flush_if_id4), .flush_id_ex (flush_id_ex4),
    .flush_ex_mem (flush_ex_mem4), .mdu_start (mdu_start4),
    .stall_cycles (stall_cycles4), .flush_count (flush_count4)
  );

  typedef struct {
    logic [8:0]      ctl;
    longint unsigned stall;
    longint unsigned flush;
    int unsigned     stall4;
    int unsigned     flush4;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: "an MDU op is outstanding" and "its result already came".
  bit              m_busy, m_early;
  longint unsigned m_stall, m_flush;
  int unsigned     m_stall4, m_flush4;
  int              mdu_cnt  = 0;
  int              next_lat = 3;

  function automatic bit hazard();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [8:0] model_ctl();
    if (!rst || mem_stall) return CtlZero;
    if (m_busy) return (mdu_done || m_early) ? CtlAllEn : CtlMduHld;
    if (ex_branch_taken) return CtlBranch;
    if (ex_is_mdu) return CtlMduGo;
    return hazard() ? CtlLdUse : CtlAllEn;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_early = 0;
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    mdu_cnt = 0;
  endtask

  // One cycle: inputs already set at this negedge; the bench MDU drives mdu_done.
  task automatic step();
    logic [8:0] c;
    exp_t e;
    if (!rst) model_reset();
    mdu_done = (mdu_cnt == 1);
    #1;
    c = model_ctl();
    e.ctl = c; e.stall = m_stall; e.flush = m_flush; e.stall4 = m_stall4; e.flush4 = m_flush4;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (mem_stall) begin
        if (mdu_done) m_early = 1;
      end else if (m_busy) begin
        if (mdu_done || m_early) begin m_busy = 0; m_early = 0; end
      end else if (!ex_branch_taken && ex_is_mdu) begin
        m_busy = 1;
      end
      if (!c[8]) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (c == CtlBranch) begin
        if (m_flush < 64'hFFFF_FFFF) m_flush++;
        if (m_flush4 < 15) m_flush4++;
      end
      if (mdu_cnt > 0) mdu_cnt--;
      if (c[0]) mdu_cnt = next_lat;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit br, input bit mdu, input bit mr, input int rd,
                        input bit u1, input int r1, input bit u2, input int r2, input bit ms);
    ex_branch_taken = br; ex_is_mdu = mdu; ex_mem_read = mr; ex_rd = AW'(rd);
    id_use_rs1 = u1; id_rs1 = AW'(r1); id_use_rs2 = u2; id_rs2 = AW'(r2); mem_stall = ms;
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a control vector; compare against queue head.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] a, a4;
    #2;
    if (q.size() > 0) begin
      e  = q.pop_front();
      a  = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, mdu_start};
      a4 = {pc_en4, en_if_id4, en_id_ex4, en_ex_mem4, en_mem_wb4,
            flush_if_id4, flush_id_ex4, flush_ex_mem4, mdu_start4};
      chk("ctl", a, e.ctl);
      chk("ctl_w4", a4, e.ctl);
      chk("stall_cycles", stall_cycles, e.stall);
      chk("flush_count", flush_count, e.flush);
      chk("stall_cycles_w4", stall_cycles4, e.stall4);
      chk("flush_count_w4", flush_count4, e.flush4);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset state.
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst = 1;
    step();

    // Branch beats a simultaneous load-use hazard.
    set_in(1, 0, 1, 5, 1, 5, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Load-use on rs1, then on rs2, then ex_rd = 0 (no stall).
    set_in(0, 0, 1, 5, 1, 5, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 1, 7, 0, 7, 1, 7, 0); step();
    set_in(0, 0, 1, 0, 1, 0, 1, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // DIV with 4-cycle latency from a fresh reset.
    rst = 0; step(); rst = 1;
    next_lat = 4;
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // mdu_done lands while memory stalls; release when the stall drops.
    next_lat = 2;
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();
    mem_stall = 1; repeat (3) step();
    mem_stall = 0; step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // Reset mid-MDU_WAIT.
    next_lat = 6;
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();
    rst = 0; repeat (2) step();
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // Long stall saturates the 4-bit counter.
    mem_stall = 1; repeat (20) step();
    mem_stall = 0; step();

    // Randomized traffic; while an MDU op is outstanding EX keeps holding it.
    for (int i = 0; i < 3000; i++) begin
      next_lat = $urandom_range(1, 6);
      if (m_busy) begin
        set_in(0, 1, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      end else begin
        set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      end
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    repeat (2) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit for the 5-stage RV32IM core. It generates the enable and bubble (flush) controls that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It resolves load-use hazards, taken-branch squashes, multi-cycle MUL/DIV occupancy of EX, and data-memory back-pressure. It also keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register-index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  REG_AW  rs1 index of instruction in ID
id_rs2  in  REG_AW  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_is_mdu  in  1  EX instruction is a multi-cycle MUL/DIV/REM
ex_branch_taken  in  1  EX resolved a taken branch/jump
mdu_done  in  1  MDU result valid, 1-cycle pulse
mem_stall  in  1  data memory not ready; freeze whole pipe
pc_en  out  1  PC register enable
en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  pipeline register enables
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  select NOP into that register's d input
mdu_start  out  1  1-cycle start pulse to MDU
stall_cycles  out  CNT_W  count of cycles with pc_en=0
flush_count  out  CNT_W  count of branch squashes

Behaviour:
- Reset is asynchronous and active-low. While rst=0: state=RUN, done_pend=0, counters=0, and all en/flush/mdu_start outputs=0. The first active edge after release operates in RUN.
- The FSM has 2 states, RUN and MDU_WAIT, plus the 1-bit register done_pend. Control outputs are combinational from state, done_pend and inputs. Counters are registered.
- Priority in every state: mem_stall > state-specific rules.
- mem_stall=1: all en=0, all flush=0, mdu_start=0. State and done_pend are held, except that mdu_done=1 sets done_pend.
- RUN, with no mem_stall, evaluated in this order:
  1. ex_branch_taken=1: all en=1, flush_if_id=1, flush_id_ex=1. This beats load-use because the ID instruction is squashed anyway.
  2. ex_is_mdu=1: mdu_start=1, pc_en=en_if_id=en_id_ex=0, en_ex_mem=1 with flush_ex_mem=1 (bubble), en_mem_wb=1. Next state is MDU_WAIT.
  3. Load-use when ex_mem_read=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd). Then pc_en=en_if_id=0, en_id_ex=1 with flush_id_ex=1, en_ex_mem=en_mem_wb=1. This lasts one cycle and needs no extra state.
  4. Otherwise all en=1 and all flush=0.
- MDU_WAIT, with no mem_stall: let done = mdu_done or done_pend.
  - done=0: same freeze and bubble outputs as RUN rule 2, but mdu_start=0.
  - done=1: all en=1, all flush=0. EX/MEM captures the MDU result, done_pend clears, and next state is RUN.
- mdu_start is asserted for exactly one cycle per MDU instruction. An MDU op always takes at least one MDU_WAIT cycle.
- ex_rd=0 never causes a load-use stall.
- stall_cycles increments on every clock with rst=1 and pc_en=0. It saturates at all-ones.
- flush_count increments when RUN rule 1 fires. It saturates at all-ones.
- Reset asserted mid-MDU_WAIT returns immediately to RUN with done_pend=0. The MDU is reset by the same rst.

Decomposition:
- A shared package holds the state enum (RUN, MDU_WAIT) and the REG_AW default constant.
- One sub-module, sat_counter (CNT_W, clk, rst, inc, q), is instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> for one cycle pc_en=0, en_if_id=0, flush_id_ex=1, en_ex_mem=1. The same stimulus with ex_rd=0 -> no stall.
- Branch plus hazard: load-use condition with ex_branch_taken=1 -> flush_if_id=flush_id_ex=1, pc_en=1. flush_count goes 0→1, stall_cycles stays 0.
- DIV: ex_is_mdu=1, mdu_done pulses 4 cycles later -> mdu_start is a single pulse. Freeze and bubble hold for 4 cycles, the release cycle has all en=1, and stall_cycles=4.
- done during mem_stall: in MDU_WAIT, mdu_done and mem_stall both high for 1 cycle, mem_stall held 2 more cycles -> all en=0 throughout. When mem_stall drops, the release happens in the same cycle and the state returns to RUN.
- Saturation: CNT_W=4 with pc_en=0 held for 20 cycles -> stall_cycles=15.
- Mid-op reset: pull rst low during MDU_WAIT -> outputs go to 0 immediately. After release the state is RUN, counters=0, and no spurious mdu_start occurs.
